// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and the copy-master state type.
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StRdA,
    StRdD,
    StWrA,
    StWrD,
    StFin
  } copy_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/ahb_lite_copy_master.sv
// Single-channel AHB-Lite block copy master: non-pipelined word read then word write per word.
module ahb_lite_copy_master
  import ahb_lite_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 start,
  input  logic [31:0]          src_addr,
  input  logic [31:0]          dst_addr,
  input  logic [CNT_WIDTH-1:0] word_count,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [31:0]          HADDR,
  output logic [1:0]           HTRANS,
  output logic                 HWRITE,
  output logic [2:0]           HSIZE,
  output logic [31:0]          HWDATA,
  input  logic [31:0]          HRDATA,
  input  logic                 HREADY,
  input  logic                 HRESP
);

  copy_state_e          state_q, state_d;
  logic [31:0]          src_q, src_d;
  logic [31:0]          dst_q, dst_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]          data_q, data_d;
  logic [31:0]          hwdata_q, hwdata_d;
  logic                 error_q, error_d;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= StIdle;
      src_q    <= '0;
      dst_q    <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      hwdata_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      hwdata_q <= hwdata_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    hwdata_d = hwdata_q;
    error_d  = error_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          error_d = 1'b0;
          if (word_count != '0) begin
            src_d   = word_align(src_addr);
            dst_d   = word_align(dst_addr);
            cnt_d   = word_count;
            state_d = StRdA;
          end else begin
            state_d = StFin;
          end
        end
      end
      StRdA: begin
        if (HREADY) state_d = StRdD;
      end
      StRdD: begin
        // Leave on the first error cycle; the slave finishes its response while we sit in FIN.
        if (HRESP == HRESP_ERROR) begin
          error_d = 1'b1;
          state_d = StFin;
        end else if (HREADY) begin
          data_d  = HRDATA;
          state_d = StWrA;
        end
      end
      StWrA: begin
        if (HREADY) begin
          hwdata_d = data_q;
          state_d  = StWrD;
        end
      end
      StWrD: begin
        if (HRESP == HRESP_ERROR) begin
          error_d = 1'b1;
          state_d = StFin;
        end else if (HREADY) begin
          src_d   = src_q + 32'd4;
          dst_d   = dst_q + 32'd4;
          cnt_d   = cnt_q - CNT_WIDTH'(1);
          state_d = (cnt_q == CNT_WIDTH'(1)) ? StFin : StRdA;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    HADDR  = '0;
    HTRANS = HTRANS_IDLE;
    HWRITE = 1'b0;
    unique case (state_q)
      StRdA: begin
        HADDR  = src_q;
        HTRANS = HTRANS_NONSEQ;
      end
      StWrA: begin
        HADDR  = dst_q;
        HTRANS = HTRANS_NONSEQ;
        HWRITE = 1'b1;
      end
      default: ;
    endcase
  end

  assign HSIZE  = HSIZE_WORD;
  assign HWDATA = hwdata_q;
  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StFin);
  assign error  = error_q;

endmodule

// File: tb/tb_ahb_lite_copy_master.sv
// Directed bench for ahb_lite_copy_master with a small behavioural AHB memory slave.
module tb_ahb_lite_copy_master;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] word_count;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  always #5 HCLK = ~HCLK;

  ahb_lite_copy_master #(
    .CNT_WIDTH(16)
  ) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .word_count(word_count),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADY    (HREADY),
    .HRESP     (HRESP)
  );

  // Slave model: 256-word memory indexed by HADDR[9:2].
  logic [31:0] mem [256];
  logic        dp_valid = 1'b0;
  logic        dp_write = 1'b0;
  logic        dp_err   = 1'b0;
  logic [31:0] dp_addr  = '0;
  int          wait_q   = 0;
  int          waits    = 0;
  int          err_at   = 0;
  int          rd_total = 0;
  int          wr_total = 0;
  logic [31:0] rd_last  = '0;
  logic [31:0] rd_prev  = '0;
  logic        pl_en    = 1'b0;
  logic [7:0]  pl_idx   = '0;
  logic [31:0] pl_data  = '0;

  assign HREADY = !dp_valid || (wait_q == 0);
  assign HRESP  = dp_valid && dp_err;
  assign HRDATA = (dp_valid && !dp_write) ? mem[dp_addr[9:2]] : 32'h0;

  always @(posedge HCLK) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    if (HRESET) begin
      dp_valid <= 1'b0;
      dp_err   <= 1'b0;
      wait_q   <= 0;
    end else begin
      if (dp_valid && HREADY) begin
        if (dp_write && !dp_err) begin
          mem[dp_addr[9:2]] <= HWDATA;
          wr_total          <= wr_total + 1;
        end
        dp_valid <= 1'b0;
      end else if (dp_valid && wait_q != 0) begin
        wait_q <= wait_q - 1;
      end
      if (HREADY && HTRANS == 2'b10) begin
        dp_valid <= 1'b1;
        dp_addr  <= HADDR;
        dp_write <= HWRITE;
        dp_err   <= 1'b0;
        wait_q   <= waits;
        if (!HWRITE) begin
          rd_total <= rd_total + 1;
          rd_prev  <= rd_last;
          rd_last  <= HADDR;
          if (rd_total + 1 == err_at) begin
            dp_err <= 1'b1;
            wait_q <= 1;
          end
        end
      end
    end
  end

  // Negedge monitor: cumulative activity counters.
  int          busy_total   = 0;
  int          busy_run     = 0;
  int          done_total   = 0;
  int          done_at      = 0;
  int          nonseq_total = 0;
  int          stab_viol    = 0;
  logic        prev_ok      = 1'b0;
  logic        prev_hready  = 1'b1;
  logic [31:0] prev_haddr   = '0;
  logic [1:0]  prev_htrans  = '0;
  logic [31:0] prev_hwdata  = '0;

  always @(negedge HCLK) begin
    if (busy) begin
      busy_total <= busy_total + 1;
      busy_run   <= busy_run + 1;
      if (done) done_at <= busy_run + 1;
    end else begin
      busy_run <= 0;
    end
    if (done) done_total <= done_total + 1;
    if (HTRANS == 2'b10) nonseq_total <= nonseq_total + 1;
    if (prev_ok && !prev_hready &&
        (HADDR !== prev_haddr || HTRANS !== prev_htrans || HWDATA !== prev_hwdata))
      stab_viol <= stab_viol + 1;
    prev_ok     <= !HRESET;
    prev_hready <= HREADY;
    prev_haddr  <= HADDR;
    prev_htrans <= HTRANS;
    prev_hwdata <= HWDATA;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] data);
    @(negedge HCLK);
    pl_en   = 1'b1;
    pl_idx  = idx;
    pl_data = data;
    @(negedge HCLK);
    pl_en = 1'b0;
  endtask

  task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    @(negedge HCLK);
    src_addr   = s;
    dst_addr   = d;
    word_count = n;
    start      = 1'b1;
    @(negedge HCLK);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge HCLK);
    end
    check32({tag, "_done_seen"}, 32'(ok), 32'd1);
    repeat (3) @(negedge HCLK);
  endtask

  int b0, d0, n0, w0, r0, s0;

  task automatic snap();
    b0 = busy_total;
    d0 = done_total;
    n0 = nonseq_total;
    w0 = wr_total;
    r0 = rd_total;
    s0 = stab_viol;
  endtask

  initial begin
    HRESET     = 1'b1;
    start      = 1'b0;
    src_addr   = '0;
    dst_addr   = '0;
    word_count = '0;
    repeat (3) @(negedge HCLK);
    check32("rst_htrans", 32'(HTRANS), 32'h0);
    check32("rst_hwrite", 32'(HWRITE), 32'h0);
    check32("rst_haddr", HADDR, 32'h0);
    check32("rst_hwdata", HWDATA, 32'h0);
    check32("rst_hsize", 32'(HSIZE), 32'h2);
    check32("rst_busy", 32'(busy), 32'h0);
    check32("rst_done", 32'(done), 32'h0);
    check32("rst_error", 32'(error), 32'h0);
    HRESET = 1'b0;

    // Zero wait states, 4 words 0x0 -> 0x100.
    preload(8'd0, 32'h1111_1111);
    preload(8'd1, 32'h2222_2222);
    preload(8'd2, 32'h3333_3333);
    preload(8'd3, 32'h4444_4444);
    snap();
    pulse_start(32'h0000_0000, 32'h0000_0100, 16'd4);
    wait_done("zw", 100);
    check32("zw_busy_cycles", 32'(busy_total - b0), 32'd17);
    check32("zw_done_cycle", 32'(done_at), 32'd17);
    check32("zw_done_pulses", 32'(done_total - d0), 32'd1);
    check32("zw_mem0", mem[64], 32'h1111_1111);
    check32("zw_mem1", mem[65], 32'h2222_2222);
    check32("zw_mem2", mem[66], 32'h3333_3333);
    check32("zw_mem3", mem[67], 32'h4444_4444);
    check32("zw_error", 32'(error), 32'h0);

    // Zero-length copy.
    snap();
    pulse_start(32'h0000_0000, 32'h0000_0100, 16'd0);
    wait_done("zl", 20);
    check32("zl_nonseq", 32'(nonseq_total - n0), 32'd0);
    check32("zl_busy_cycles", 32'(busy_total - b0), 32'd1);
    check32("zl_done_cycle", 32'(done_at), 32'd1);
    check32("zl_done_pulses", 32'(done_total - d0), 32'd1);

    // Two wait states per data phase, misaligned addresses 0x41 -> 0x182.
    preload(8'd16, 32'hA5A5_0001);
    preload(8'd17, 32'h5A5A_0002);
    waits = 2;
    snap();
    pulse_start(32'h0000_0041, 32'h0000_0182, 16'd2);
    wait_done("ws", 100);
    waits = 0;
    check32("ws_busy_cycles", 32'(busy_total - b0), 32'd17);
    check32("ws_stable", 32'(stab_viol - s0), 32'd0);
    check32("ws_mem0", mem[96], 32'hA5A5_0001);
    check32("ws_mem1", mem[97], 32'h5A5A_0002);

    // Error response on the second read of a 3-word copy.
    preload(8'd8, 32'hC0DE_0000);
    preload(8'd9, 32'hC0DE_0001);
    preload(8'd10, 32'hC0DE_0002);
    preload(8'd193, 32'h5EED_5EED);
    snap();
    err_at = r0 + 2;
    pulse_start(32'h0000_0020, 32'h0000_0300, 16'd3);
    wait_done("er", 100);
    err_at = 0;
    check32("er_writes", 32'(wr_total - w0), 32'd1);
    check32("er_reads", 32'(rd_total - r0), 32'd2);
    check32("er_mem0", mem[192], 32'hC0DE_0000);
    check32("er_mem1_untouched", mem[193], 32'h5EED_5EED);
    check32("er_error", 32'(error), 32'h1);
    check32("er_done_pulses", 32'(done_total - d0), 32'd1);
    pulse_start(32'h0000_0000, 32'h0000_0000, 16'd0);
    wait_done("er_clr", 20);
    check32("er_error_cleared", 32'(error), 32'h0);

    // Reset during the write data phase of word 2 of 4.
    snap();
    pulse_start(32'h0000_0000, 32'h0000_0380, 16'd4);
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 100; i++) begin
        if (dp_valid && dp_write && (wr_total - w0) == 1) begin
          hit = 1'b1;
          break;
        end
        @(negedge HCLK);
      end
      check32("rm_reached_wrd2", 32'(hit), 32'd1);
    end
    HRESET = 1'b1;
    @(negedge HCLK);
    HRESET = 1'b0;
    check32("rm_htrans", 32'(HTRANS), 32'h0);
    check32("rm_busy", 32'(busy), 32'h0);
    check32("rm_error", 32'(error), 32'h0);
    repeat (10) @(negedge HCLK);
    check32("rm_no_done", 32'(done_total - d0), 32'd0);
    check32("rm_writes", 32'(wr_total - w0), 32'd1);

    // Address wrap with a second start issued while busy.
    preload(8'd255, 32'hDEAD_BEEF);
    preload(8'd0, 32'h0BAD_F00D);
    snap();
    pulse_start(32'hFFFF_FFFC, 32'h0000_0200, 16'd2);
    @(negedge HCLK);
    start      = 1'b1;
    src_addr   = 32'h0000_0040;
    dst_addr   = 32'h0000_0080;
    word_count = 16'd5;
    @(negedge HCLK);
    start = 1'b0;
    wait_done("wr", 100);
    repeat (10) @(negedge HCLK);
    check32("wr_rd_first", rd_prev, 32'hFFFF_FFFC);
    check32("wr_rd_second", rd_last, 32'h0000_0000);
    check32("wr_reads", 32'(rd_total - r0), 32'd2);
    check32("wr_done_pulses", 32'(done_total - d0), 32'd1);
    check32("wr_busy_cycles", 32'(busy_total - b0), 32'd9);
    check32("wr_mem0", mem[128], 32'hDEAD_BEEF);
    check32("wr_mem1", mem[129], 32'h0BAD_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_lite_copy_master.md
Name: ahb_lite_copy_master

Overview:
- Single-channel AHB-Lite bus master; copies a block of 32-bit words from a source region to a destination region.
- Sits directly upstream of the on-chip AHB memory slave, through the address decoder and slave mux.
- Generates non-pipelined word reads followed by word writes; reports busy, done and error to the controlling logic.

Parameters:
- CNT_WIDTH, 16, width of word_count and internal remaining-words counter (max block = 2^CNT_WIDTH-1 words)

Ports:
- HCLK  in  1  system clock; all logic on rising edge
- HRESET  in  1  synchronous, active-high reset
- start  in  1  single-cycle request; sampled only in IDLE
- src_addr  in  32  source byte address; bits[1:0] ignored (forced 00)
- dst_addr  in  32  destination byte address; bits[1:0] ignored
- word_count  in  CNT_WIDTH  number of words to copy
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse on completion (normal or error)
- error  out  1  sticky; set on HRESP error; cleared on next accepted start
- HADDR  out  32  AHB address
- HTRANS  out  2  IDLE=00 or NONSEQ=10 only
- HWRITE  out  1  transfer direction
- HSIZE  out  3  constant 3'b010 (word)
- HWDATA  out  32  write data, valid in write data phase
- HRDATA  in  32  read data from slave mux
- HREADY  in  1  bus ready (muxed HREADYOUT)
- HRESP  in  1  0=OKAY, 1=ERROR

Behaviour:
- Reset (HRESET=1 at edge): state IDLE; HTRANS=00, HWRITE=0, HADDR=0, HWDATA=0, busy=0, done=0, error=0; data register and counters cleared.
- A reset mid-copy abandons the transfer; HTRANS=IDLE from the next cycle; no done pulse.
- States: IDLE, RD_A, RD_D, WR_A, WR_D, FIN.
- IDLE:
  - start=1 with word_count!=0: latch aligned src/dst and count; clear error; go RD_A.
  - start=1 with word_count=0: clear error; go FIN (no bus activity).
- RD_A: drive HADDR=src_ptr, HTRANS=NONSEQ, HWRITE=0.
  - Hold all address/control until HREADY=1 at an edge, then go RD_D.
- RD_D: drive HTRANS=IDLE.
  - HREADY=1 and HRESP=0: capture HRDATA into data register; go WR_A.
  - HRESP=1 in either cycle of the two-cycle error response: set error; go FIN (remaining words skipped).
- WR_A: drive HADDR=dst_ptr, HTRANS=NONSEQ, HWRITE=1.
  - Hold until HREADY=1, then go WR_D.
- WR_D: drive HTRANS=IDLE, HWDATA=data register; hold HWDATA until HREADY=1.
  - On HREADY=1: src_ptr+=4, dst_ptr+=4 (32-bit wrap, 0xFFFFFFFC -> 0x00000000), count-=1.
  - Go RD_A if the new count !=0, else FIN.
  - HRESP error: as in RD_D.
- FIN: done=1 for exactly one cycle; go IDLE.
- busy=1 in every state except IDLE.
- start while busy: ignored, no effect.
- Throughput with zero wait states: 4 cycles per word. A copy of N words has busy high for 4N+1 cycles (FIN included), with done in the last of them.
- HWDATA changes only on entry to WR_D; it holds its value otherwise.
- HSIZE is constant 3'b010 in all states, including reset.

Decomposition:
- Shared package ahb_lite_pkg:
  - HTRANS_IDLE=2'b00, HTRANS_NONSEQ=2'b10
  - HSIZE_WORD=3'b010
  - HRESP_OKAY/HRESP_ERROR
  - copy-master state enum
- Single module; no sub-module. Pointer and counter logic is small enough to stay inline.

Test Plan:
- Zero wait states: src=0x0000_0000 holding 0x11111111..0x44444444, dst=0x0000_0100, count=4, HREADY=1 -> busy high 17 cycles, done pulse on cycle 17, memory 0x100..0x10C = 0x11111111..0x44444444, error=0.
- Zero-length: count=0, start=1 -> no NONSEQ ever driven, done pulses in the cycle after start, busy high exactly 1 cycle.
- Wait states: HREADY low for 2 cycles in every data phase, count=2 -> HADDR/HTRANS/HWDATA stable while HREADY=0, copy correct, busy high 2*8+1=17 cycles.
- Error: slave returns HRESP=1 (two-cycle error response) on the 2nd read, count=3 -> exactly 1 write performed, error=1, done pulses once; a new start clears error.
- Reset mid-copy: assert HRESET during WR_D of word 2 of 4 -> next cycle HTRANS=00, busy=0, done never pulses, error=0.
- Wrap and ignored start: src=0xFFFF_FFFC, count=2, with a second start issued while busy -> second read at 0x0000_0000, second start has no effect, exactly one done pulse.
